// File: rtl/mm_bus_access.sv
// mm_bus_access: memory stage between ex and wb.
// Drives a registered request/acknowledge bus, stalls upstream while an
// access is outstanding, and holds the mm/wb result register.
// Optional access timeout: define MM_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | no access outstanding; ex inputs are evaluated every cycle
//   BUSY  | bus request held until bus_ack (or timeout when enabled)
module mm_bus_access #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              flush,
  input  logic [1:0]        mem_access_type,
  input  logic [2:0]        mem_access_size,
  input  logic              mem_access_signed,
  input  logic [ADDR_W-1:0] mem_access_addr_i,
  input  logic [31:0]       data_i,
  input  logic [4:0]        reg_addr_i,
  output logic              stall,
  output logic              wb_valid,
  output logic [31:0]       data_o,
  output logic [4:0]        wb_reg_addr,
  output logic [4:0]        bypass_reg_addr_mm,
  output logic              alignment_err,
  output logic              bus_err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_byte_en,
  output logic              bus_read,
  output logic              bus_write,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  // Encodings shared with the decode stage.
  localparam logic [1:0] MEM_ACCESS_TYPE_M2R    = 2'd1;
  localparam logic [1:0] MEM_ACCESS_TYPE_R2M    = 2'd2;
  localparam logic [2:0] MEM_ACCESS_LENGTH_WORD = 3'd0;
  localparam logic [2:0] MEM_ACCESS_LENGTH_HALF = 3'd1;
  localparam logic [2:0] MEM_ACCESS_LENGTH_BYTE = 3'd2;
  localparam logic [2:0] MEM_ACCESS_LENGTH_LEFT = 3'd3;
  localparam logic [2:0] MEM_ACCESS_LENGTH_RIGHT = 3'd4;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      r_state;
  logic        r_load;
  logic [2:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [31:0] r_data;
  logic [4:0]  r_reg;
  logic        r_flushed;
  logic        r_wb_valid;
  logic [31:0] r_data_o;
  logic [4:0]  r_wb_reg;
  logic        r_align_err;
  logic [ADDR_W-1:0] r_err_addr;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_be;
  logic        r_bus_read;
  logic        r_bus_write;

  logic        w_busy;
  logic        w_is_mem;
  logic        w_aligned;
  logic        w_accept;
  logic        w_timeout;
  logic [1:0]  w_a;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rd_shr;
  logic [15:0] w_lane16;
  logic [31:0] w_rdata_fmt;
  logic [4:0]  w_sh_lane;
  logic [4:0]  w_sh_left;

  // An out-of-range TIMEOUT_CYCLES would let the wait counter wrap before
  // the compare can hit; nothing is built for it.
  if (TIMEOUT_CYCLES >= (1 << TO_W)) begin : g_timeout_range
  end

  assign w_busy    = (r_state == S_BUSY);
  assign w_is_mem  = req_valid & ((mem_access_type == MEM_ACCESS_TYPE_M2R) |
                                  (mem_access_type == MEM_ACCESS_TYPE_R2M));
  assign w_a       = mem_access_addr_i[1:0];
  assign w_aligned = (mem_access_size == MEM_ACCESS_LENGTH_HALF) ? ~w_a[0] :
                     (mem_access_size == MEM_ACCESS_LENGTH_WORD) ? (w_a == 2'b00) : 1'b1;
  assign w_accept  = ~w_busy & w_is_mem & w_aligned & ~flush;
  assign stall     = ~rst & (w_accept | (w_busy & ~bus_ack & ~w_timeout));

  // Store lane placement and byte enables from the ex-stage address.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = data_i;
    case (mem_access_size)
      MEM_ACCESS_LENGTH_BYTE: begin
        w_be    = 4'b0001 << w_a;
        w_wdata = {4{data_i[7:0]}};
      end
      MEM_ACCESS_LENGTH_HALF: begin
        w_be    = w_a[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{data_i[15:0]}};
      end
      MEM_ACCESS_LENGTH_LEFT: begin
        w_be    = {w_a[1] & w_a[0], w_a[1], w_a[1] | w_a[0], 1'b1};
        w_wdata = data_i >> {~w_a, 3'b000};
      end
      MEM_ACCESS_LENGTH_RIGHT: begin
        w_be    = {1'b1, ~(w_a[1] & w_a[0]), ~w_a[1], ~(w_a[1] | w_a[0])};
        w_wdata = data_i << {w_a, 3'b000};
      end
      default: ;
    endcase
  end

  assign w_sh_lane = {r_lane, 3'b000};
  assign w_sh_left = {~r_lane, 3'b000};
  assign w_rd_shr  = bus_rdata >> w_sh_lane;
  assign w_lane16  = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  // Load extraction/merge against the latched op fields.
  always_comb begin
    w_rdata_fmt = bus_rdata;
    case (r_size)
      MEM_ACCESS_LENGTH_BYTE:
        w_rdata_fmt = {{24{r_signed & w_rd_shr[7]}}, w_rd_shr[7:0]};
      MEM_ACCESS_LENGTH_HALF:
        w_rdata_fmt = {{16{r_signed & w_lane16[15]}}, w_lane16};
      MEM_ACCESS_LENGTH_LEFT:
        w_rdata_fmt = (bus_rdata << w_sh_left) | (r_data & ~(32'hFFFF_FFFF << w_sh_left));
      MEM_ACCESS_LENGTH_RIGHT:
        w_rdata_fmt = w_rd_shr | (r_data & ~(32'hFFFF_FFFF >> w_sh_lane));
      default: ;
    endcase
  end

`ifdef MM_TIMEOUT_EN
  logic [TO_W-1:0]   r_wait_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_bus_err;

  // Wait counter: zero in IDLE, counts BUSY cycles that see no ack.
  always_ff @(posedge clk) begin
    if (rst || !w_busy) r_wait_cnt <= '0;
    else if (!bus_ack)  r_wait_cnt <= r_wait_cnt + 1'b1;
  end

  assign w_timeout = w_busy & ~bus_ack & (r_wait_cnt == TO_W'(TIMEOUT_CYCLES));
  assign bus_err   = r_bus_err;
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif

  // Control FSM, bus request registers and the mm/wb result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_load      <= 1'b0;
      r_size      <= '0;
      r_signed    <= 1'b0;
      r_lane      <= '0;
      r_data      <= '0;
      r_reg       <= '0;
      r_flushed   <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_data_o    <= '0;
      r_wb_reg    <= '0;
      r_align_err <= 1'b0;
      r_err_addr  <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
      r_bus_read  <= 1'b0;
      r_bus_write <= 1'b0;
`ifdef MM_TIMEOUT_EN
      r_addr      <= '0;
      r_bus_err   <= 1'b0;
`endif
    end else begin
      r_wb_valid  <= 1'b0;
      r_align_err <= 1'b0;
`ifdef MM_TIMEOUT_EN
      r_bus_err   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (req_valid && !flush) begin
            if (!w_is_mem) begin
              r_wb_valid <= 1'b1;
              r_data_o   <= data_i;
              r_wb_reg   <= reg_addr_i;
            end else if (!w_aligned) begin
              r_align_err <= 1'b1;
              r_err_addr  <= mem_access_addr_i;
            end else begin
              r_state     <= S_BUSY;
              r_load      <= (mem_access_type == MEM_ACCESS_TYPE_M2R);
              r_size      <= mem_access_size;
              r_signed    <= mem_access_signed;
              r_lane      <= w_a;
              r_data      <= data_i;
              r_reg       <= reg_addr_i;
              r_flushed   <= 1'b0;
              r_bus_read  <= (mem_access_type == MEM_ACCESS_TYPE_M2R);
              r_bus_write <= (mem_access_type == MEM_ACCESS_TYPE_R2M);
              r_bus_addr  <= {mem_access_addr_i[ADDR_W-1:2], 2'b00};
              r_bus_wdata <= w_wdata;
              r_bus_be    <= w_be;
`ifdef MM_TIMEOUT_EN
              r_addr      <= mem_access_addr_i;
`endif
            end
          end
        end
        S_BUSY: begin
          if (flush) r_flushed <= 1'b1;
          if (bus_ack) begin
            r_state     <= S_IDLE;
            r_bus_read  <= 1'b0;
            r_bus_write <= 1'b0;
            // A flush seen at any point of the access suppresses write-back.
            if (!(r_flushed || flush)) begin
              r_wb_valid <= 1'b1;
              r_data_o   <= r_load ? w_rdata_fmt : r_data;
              r_wb_reg   <= r_reg;
            end
          end
`ifdef MM_TIMEOUT_EN
          else if (w_timeout) begin
            r_state     <= S_IDLE;
            r_bus_read  <= 1'b0;
            r_bus_write <= 1'b0;
            r_bus_err   <= 1'b1;
            r_err_addr  <= r_addr;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wb_valid           = r_wb_valid;
  assign data_o             = r_data_o;
  assign wb_reg_addr        = r_wb_reg;
  assign bypass_reg_addr_mm = r_reg;
  assign alignment_err      = r_align_err;
  assign err_addr           = r_err_addr;
  assign bus_addr           = r_bus_addr;
  assign bus_wdata          = r_bus_wdata;
  assign bus_byte_en        = r_bus_be;
  assign bus_read           = r_bus_read;
  assign bus_write          = r_bus_write;

endmodule

// File: tb/tb_mm_bus_access.sv
// Bench for mm_bus_access: transaction-level reference model plus a
// per-cycle compare on the falling edge, directed cases and random ops.
module tb_mm_bus_access;

  localparam int TO = 4;
`ifdef MM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [1:0] T_NONE = 2'd0, T_M2R = 2'd1, T_R2M = 2'd2, T_R2R = 2'd3;
  localparam logic [2:0] SZ_WORD = 3'd0, SZ_HALF = 3'd1, SZ_BYTE = 3'd2,
                         SZ_LEFT = 3'd3, SZ_RIGHT = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, flush = 1'b0;
  logic [1:0]  mem_access_type = '0;
  logic [2:0]  mem_access_size = '0;
  logic        mem_access_signed = 1'b0;
  logic [31:0] mem_access_addr_i = '0, data_i = '0;
  logic [4:0]  reg_addr_i = '0;
  logic        stall, wb_valid, alignment_err, bus_err, bus_read, bus_write;
  logic [31:0] data_o, err_addr, bus_addr, bus_wdata;
  logic [4:0]  wb_reg_addr, bypass_reg_addr_mm;
  logic [3:0]  bus_byte_en;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  mm_bus_access #(.ADDR_W(32), .TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .flush(flush),
    .mem_access_type(mem_access_type), .mem_access_size(mem_access_size),
    .mem_access_signed(mem_access_signed), .mem_access_addr_i(mem_access_addr_i),
    .data_i(data_i), .reg_addr_i(reg_addr_i), .stall(stall), .wb_valid(wb_valid),
    .data_o(data_o), .wb_reg_addr(wb_reg_addr), .bypass_reg_addr_mm(bypass_reg_addr_mm),
    .alignment_err(alignment_err), .bus_err(bus_err), .err_addr(err_addr),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_byte_en(bus_byte_en),
    .bus_read(bus_read), .bus_write(bus_write), .bus_rdata(bus_rdata), .bus_ack(bus_ack));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  // ---------------- reference model (specification arithmetic) ----------------
  function automatic bit m_aligned(input logic [2:0] sz, input logic [31:0] a);
    if (sz == SZ_HALF) return (a % 2) == 0;
    if (sz == SZ_WORD) return (a % 4) == 0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] sz, input int a);
    case (sz)
      SZ_BYTE:  return 4'(1 << a);
      SZ_HALF:  return (a >= 2) ? 4'd12 : 4'd3;
      SZ_LEFT:  return 4'((1 << (a + 1)) - 1);
      SZ_RIGHT: return 4'((15 << a) & 15);
      default:  return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] sz, input int a, input logic [31:0] d);
    case (sz)
      SZ_BYTE:  return (d & 32'hFF) * 32'h0101_0101;
      SZ_HALF:  return (d & 32'hFFFF) * 32'h0001_0001;
      SZ_LEFT:  return d >> (8 * (3 - a));
      SZ_RIGHT: return d << (8 * a);
      default:  return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] sz, input logic sg, input int a,
                                         input logic [31:0] rd, input logic [31:0] old);
    logic [31:0] v;
    logic [31:0] ones;
    int s;
    ones = 32'hFFFF_FFFF;
    case (sz)
      SZ_BYTE: begin
        v = (rd >> (8 * a)) & 32'hFF;
        if (sg && v >= 32'd128) v = v - 32'd256;
      end
      SZ_HALF: begin
        v = (rd >> (16 * (a / 2))) & 32'hFFFF;
        if (sg && v >= 32'd32768) v = v - 32'd65536;
      end
      SZ_LEFT: begin
        s = 8 * (3 - a);
        v = (rd << s) | (old & ~(ones << s));
      end
      SZ_RIGHT: begin
        s = 8 * a;
        v = (rd >> s) | (old & ~(ones >> s));
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  bit          m_busy = 0, m_load_op = 0, m_sg = 0, m_fl = 0;
  logic [2:0]  m_sz = '0;
  logic [31:0] m_a = '0, m_d = '0;
  logic [4:0]  m_reg = '0;
  int          m_wait = 0;
  bit          e_wb_valid = 0, e_align = 0, e_buserr = 0, e_rd = 0, e_wr = 0;
  logic [31:0] e_data = '0, e_err_addr = '0, e_addr = '0, e_wdata = '0;
  logic [4:0]  e_wb_reg = '0;
  logic [3:0]  e_be = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; e_wb_valid = 0; e_align = 0; e_buserr = 0; e_rd = 0; e_wr = 0;
      e_data = '0; e_err_addr = '0; e_addr = '0; e_wdata = '0; e_wb_reg = '0; e_be = '0;
    end else begin
      e_wb_valid = 0; e_align = 0; e_buserr = 0;
      if (m_busy) begin
        if (flush) m_fl = 1;
        if (bus_ack) begin
          m_busy = 0; e_rd = 0; e_wr = 0;
          if (!m_fl) begin
            e_wb_valid = 1;
            e_wb_reg   = m_reg;
            e_data     = m_load_op ? m_load(m_sz, m_sg, int'(m_a % 4), bus_rdata, m_d) : m_d;
          end
        end else if (TO_EN && m_wait == TO) begin
          m_busy = 0; e_rd = 0; e_wr = 0; e_buserr = 1; e_err_addr = m_a;
        end else begin
          m_wait++;
        end
      end else if (req_valid && !flush) begin
        if (mem_access_type != T_M2R && mem_access_type != T_R2M) begin
          e_wb_valid = 1; e_data = data_i; e_wb_reg = reg_addr_i;
        end else if (!m_aligned(mem_access_size, mem_access_addr_i)) begin
          e_align = 1; e_err_addr = mem_access_addr_i;
        end else begin
          m_busy = 1; m_wait = 0; m_fl = 0;
          m_load_op = (mem_access_type == T_M2R);
          m_sz = mem_access_size; m_sg = mem_access_signed;
          m_a = mem_access_addr_i; m_d = data_i; m_reg = reg_addr_i;
          e_rd = m_load_op; e_wr = !m_load_op;
          e_addr  = mem_access_addr_i - (mem_access_addr_i % 4);
          e_wdata = m_wdata(m_sz, int'(m_a % 4), data_i);
          e_be    = m_be(m_sz, int'(m_a % 4));
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit exp_stall;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("wb_valid", {31'd0, wb_valid}, {31'd0, e_wb_valid});
      if (e_wb_valid) begin
        chk("data_o", data_o, e_data);
        chk("wb_reg_addr", {27'd0, wb_reg_addr}, {27'd0, e_wb_reg});
      end
      chk("alignment_err", {31'd0, alignment_err}, {31'd0, e_align});
      chk("bus_err", {31'd0, bus_err}, {31'd0, e_buserr});
      chk("err_addr", err_addr, e_err_addr);
      chk("bus_read", {31'd0, bus_read}, {31'd0, e_rd});
      chk("bus_write", {31'd0, bus_write}, {31'd0, e_wr});
      if (e_rd || e_wr) begin
        chk("bus_addr", bus_addr, e_addr);
        chk("bus_wdata", bus_wdata, e_wdata);
        chk("bus_byte_en", {28'd0, bus_byte_en}, {28'd0, e_be});
      end
      if (m_busy) chk("bypass_reg", {27'd0, bypass_reg_addr_mm}, {27'd0, m_reg});
      if (!rst) begin
        if (m_busy)
          exp_stall = !bus_ack && !(TO_EN && m_wait == TO);
        else
          exp_stall = req_valid && !flush &&
                      (mem_access_type == T_M2R || mem_access_type == T_R2M) &&
                      m_aligned(mem_access_size, mem_access_addr_i);
        chk("stall", {31'd0, stall}, {31'd0, exp_stall});
      end
    end
  end

  // ---------------- stimulus ----------------
  int          stall_cnt, busy_cyc;
  bit          saw_rd;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_wr;

  task automatic op(input logic v, input logic [1:0] t, input logic [2:0] sz, input logic sg,
                    input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                    input logic fl0, input int ack_dly, input logic [31:0] rd, input int fl_k);
    int k;
    req_valid = v; mem_access_type = t; mem_access_size = sz; mem_access_signed = sg;
    mem_access_addr_i = a; data_i = d; reg_addr_i = r; flush = fl0; bus_ack = 1'b0;
    stall_cnt = 0; saw_rd = 0; busy_cyc = 0;
    #1 stall_cnt += int'(stall);
    @(posedge clk); #1;
    flush = 1'b0;
    k = 0;
    while (m_busy) begin
      if (k == 0) begin
        last_addr = bus_addr; last_be = bus_byte_en; last_wdata = bus_wdata; last_wr = bus_write;
      end
      saw_rd |= bus_read;
      bus_ack   = (k == ack_dly);
      bus_rdata = (k == ack_dly) ? rd : $urandom();
      flush     = (k == fl_k);
      #1 stall_cnt += int'(stall);
      @(posedge clk); #1;
      k++;
      busy_cyc = k;
      if (k >= 1000) begin
        checks++; errors++;
        $display("FAIL busy_bound actual=%0d required=<1000", k);
        break;
      end
    end
    saw_rd |= bus_read;
    bus_ack = 1'b0; flush = 1'b0; req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus_ack = 1'($urandom_range(0, 1));
      bus_rdata = $urandom();
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
  endtask

  logic [1:0]  r_t;
  logic [2:0]  r_sz;
  logic [31:0] r_a;
  int          r_dly, r_fk;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    chk("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("reset_bus_read", {31'd0, bus_read}, 32'd0);
    rst = 1'b0;

    // Non-memory op, latency 1, no stall.
    op(1, T_NONE, SZ_WORD, 0, 32'h0, 32'h1234_5678, 5'd5, 0, 0, 0, -1);
    chk("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("alu_data", data_o, 32'h1234_5678);
    chk("alu_reg", {27'd0, wb_reg_addr}, 32'd5);
    chk("alu_stall_cnt", stall_cnt, 0);

    // LB signed at 0x103 with 3 wait cycles.
    op(1, T_M2R, SZ_BYTE, 1, 32'h103, 32'h0, 5'd7, 0, 3, 32'h8000_0000, -1);
    chk("lb_addr", last_addr, 32'h100);
    chk("lb_be", {28'd0, last_be}, 32'h8);
    chk("lb_stall_cnt", stall_cnt, 4);
    chk("lb_data", data_o, 32'hFFFF_FF80);

    // SWL then LWL at 0x101.
    op(1, T_R2M, SZ_LEFT, 0, 32'h101, 32'hAABB_CCDD, 5'd0, 0, 0, 32'h0, -1);
    chk("swl_write", {31'd0, last_wr}, 32'd1);
    chk("swl_be", {28'd0, last_be}, 32'h3);
    chk("swl_wdata", last_wdata, 32'h0000_AABB);
    chk("swl_wb_valid", {31'd0, wb_valid}, 32'd1);
    op(1, T_M2R, SZ_LEFT, 0, 32'h101, 32'hAABB_CCDD, 5'd9, 0, 0, 32'h1122_3344, -1);
    chk("lwl_data", data_o, 32'h3344_CCDD);

    // Misaligned LW.
    op(1, T_M2R, SZ_WORD, 0, 32'h102, 32'h0, 5'd3, 0, 0, 32'h0, -1);
    chk("lw_mis_err", {31'd0, alignment_err}, 32'd1);
    chk("lw_mis_addr", err_addr, 32'h102);
    chk("lw_mis_no_read", {31'd0, saw_rd}, 32'd0);
    chk("lw_mis_wb_valid", {31'd0, wb_valid}, 32'd0);

    // Flush in the first BUSY cycle, ack two cycles later.
    op(1, T_M2R, SZ_WORD, 0, 32'h200, 32'h0, 5'd4, 0, 2, 32'hDEAD_BEEF, 0);
    chk("flush_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("flush_stall_cnt", stall_cnt, 3);

    // Flush in IDLE prevents acceptance.
    op(1, T_M2R, SZ_WORD, 0, 32'h300, 32'h0, 5'd4, 1, 0, 32'h0, -1);
    chk("idle_flush_busy", busy_cyc, 0);

    // Long wait: timeout when enabled, otherwise completion after 20 cycles.
    op(1, T_M2R, SZ_WORD, 0, 32'h404, 32'h0, 5'd6, 0, 20, 32'h5555_AAAA, -1);
`ifdef MM_TIMEOUT_EN
    chk("to_busy_cycles", busy_cyc, 5);
    chk("to_bus_err", {31'd0, bus_err}, 32'd1);
    chk("to_err_addr", err_addr, 32'h404);
    chk("to_bus_read", {31'd0, bus_read}, 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("to_late_ack", {31'd0, wb_valid}, 32'd0);
`else
    chk("noto_busy_cycles", busy_cyc, 21);
    chk("noto_data", data_o, 32'h5555_AAAA);
`endif

    // Reset while BUSY.
    req_valid = 1'b1; mem_access_type = T_M2R; mem_access_size = SZ_WORD;
    mem_access_addr_i = 32'h500; data_i = 32'h0; reg_addr_i = 5'd2;
    @(posedge clk); #1;
    chk("pre_rst_read", {31'd0, bus_read}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_bus_read", {31'd0, bus_read}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_data_o", data_o, 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0; req_valid = 1'b0;
    idle(2);

    // Random ops.
    for (int i = 0; i < 400; i++) begin
      r_t   = 2'($urandom_range(0, 3));
      r_sz  = 3'($urandom_range(0, 4));
      r_a   = $urandom();
      r_dly = $urandom_range(0, 6);
      r_fk  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 6) : -1;
      op(($urandom_range(0, 7) != 0), r_t, r_sz, 1'($urandom_range(0, 1)), r_a, $urandom(),
         5'($urandom_range(0, 31)), ($urandom_range(0, 9) == 0), r_dly, $urandom(), r_fk);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_bus_access.md
Name: mm_bus_access

Overview:
- Next-generation memory-stage unit for the MIPS pipeline. It sits between the ex stage and wb.
- Replaces the zero-wait SRAM assumption with a registered request/acknowledge bus. The bus can take any number of wait states.
- Stalls the pipeline while an access is outstanding and includes the mm/wb result register.
- Supports an optional access timeout and reports bus errors to the exception logic.

Parameters:
- ADDR_W, 32, address width of the ex input and the bus address; bus_addr[1:0] is always 0.
- TIMEOUT_CYCLES, 255, number of BUSY cycles without bus_ack before the access is aborted.
- TO_W, 8, width of the wait counter; requires TIMEOUT_CYCLES < 2**TO_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- req_valid  in  1  ex presents an instruction
- flush  in  1  discard current/outstanding result (exception or branch flush)
- mem_access_type  in  2  `MEM_ACCESS_TYPE_* from defs.v
- mem_access_size  in  3  `MEM_ACCESS_LENGTH_* from defs.v
- mem_access_signed  in  1  sign-extend LB/LH
- mem_access_addr_i  in  ADDR_W  effective address
- data_i  in  32  store data / ALU result / old rt for LWL-LWR merge
- reg_addr_i  in  5  destination register
- stall  out  1  hold ex and earlier stages (combinational)
- wb_valid  out  1  data_o/wb_reg_addr valid for wb (registered)
- data_o  out  32  write-back value (registered)
- wb_reg_addr  out  5  registered reg_addr_i
- bypass_reg_addr_mm  out  5  reg_addr_i of the in-flight op, for the forwarding mux
- alignment_err  out  1  registered 1-cycle pulse
- bus_err  out  1  registered 1-cycle pulse on timeout
- err_addr  out  ADDR_W  faulting address, held until the next error
- bus_addr  out  ADDR_W  word-aligned address
- bus_wdata  out  32  lane-positioned store data
- bus_byte_en  out  4  byte lanes
- bus_read  out  1  read request, level
- bus_write  out  1  write request, level
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  completes the access in the cycle it is high

Behaviour:
- States: IDLE, BUSY. Reset and every reset cycle force IDLE. All registered outputs reset to 0.
- An outstanding bus request is dropped on the next edge after rst. An ack arriving in IDLE is ignored.
- Memory op: req_valid and type M2R/R2M. Any other type is a non-memory op.
- Non-memory op in IDLE, no flush:
  - next cycle wb_valid=1, data_o=data_i, wb_reg_addr=reg_addr_i.
  - Latency 1, stall=0.
- Memory op in IDLE:
  - Alignment is checked as follows: HALF needs addr[0]=0; WORD needs addr[1:0]=0.
  - Misaligned:
    - no bus cycle; next cycle alignment_err=1, err_addr=addr, wb_valid=0, stall=0.
  - Aligned, cycle N:
    - stall=1; op fields are latched.
    - BUSY from N+1, with bus_read/bus_write, addr, wdata and byte_en registered.
- BUSY:
  - stall = ~bus_ack.
  - On ack in cycle M: the request drops at M+1 and the state returns to IDLE at M+1.
  - Loads: data_o is written at M+1 from bus_rdata and wb_valid=1. Stores: wb_valid=1, data_o=latched data_i.
  - Minimum memory-op latency is 2 cycles (ack at N+1).
  - Upstream holds its inputs while stall=1. Inputs are ignored in BUSY.
- Load formatting:
  - BYTE/HALF select the lane by addr[1:0]/addr[1], with sign or zero extension.
  - LEFT_WORD: shift = (3-addr[1:0])*8; data_o = (rdata<<shift) | (data_i & ~(ones<<shift)).
  - RIGHT_WORD: shift = addr[1:0]*8; data_o = (rdata>>shift) | (data_i & ~(ones>>shift)).
- Store data:
  - BYTE: replicated x4. HALF: replicated x2.
  - LEFT_WORD: data_i>>((3-a)*8). RIGHT_WORD: data_i<<(a*8).
- byte_en:
  - BYTE: one-hot on a.
  - HALF: 0011 or 1100.
  - WORD: 1111.
  - LEFT: {a1&a0, a1, a1|a0, 1}.
  - RIGHT: {1, ~(a1&a0), ~a1, ~(a1|a0)}.
  - Reads use the same byte_en.
- flush:
  - In IDLE: no acceptance, wb_valid=0 next cycle, no error pulses.
  - In BUSY: the bus cycle runs to ack (it cannot be aborted), but the completion produces wb_valid=0. Stall is still ~bus_ack.
- wb_valid is 0 in every cycle not described above.

Optional Feature:
- MM_TIMEOUT_EN defined:
  - A TO_W counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the count equals TIMEOUT_CYCLES with no ack: the request drops next edge, IDLE, bus_err=1 (1 cycle), err_addr=latched addr, wb_valid=0, stall=0 in that cycle.
  - An ack in the same cycle as the count reaching TIMEOUT_CYCLES wins: normal completion.
- MM_TIMEOUT_EN undefined: no counter, BUSY waits indefinitely, bus_err tied 0.

Test Plan:
- Non-memory op, data_i=32'h1234_5678, reg 5 -> next cycle wb_valid=1, data_o=32'h1234_5678, wb_reg_addr=5, stall never high.
- LB signed, addr 0x103, ack after 3 wait cycles with rdata 32'h8000_0000 -> bus_addr 0x100, byte_en 1000, stall high 4 cycles, data_o=32'hFFFF_FF80.
- SWL addr 0x101, data_i 32'hAABB_CCDD, immediate ack -> bus_write=1, byte_en 0011, wdata 32'h0000_AABB; LWL addr 0x101, rdata 32'h1122_3344, data_i 32'hAABB_CCDD -> data_o 32'h3344_CCDD.
- LW addr 0x102 -> alignment_err pulse, err_addr 0x102, bus_read never asserted, wb_valid=0.
- Load accepted, flush in first BUSY cycle, ack 2 cycles later -> no wb_valid, stall drops in the ack cycle.
- MM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_err after 5th BUSY cycle, bus_read low next edge, a later ack ignored; rst mid-BUSY -> bus_read low after the reset edge, all outputs 0.
